// File: rtl/lane_rotate_seq.sv
// Lane sequencer/rotator: walks lane indices 0..NUM_LANES-1 through an external
// offset decoder and emits each lane rotated left by the returned offset.
module lane_rotate_seq #(
   parameter int LANE_W    = 64,
   parameter int NUM_LANES = 25,
   parameter int IDX_W     = 5,
   parameter int SH_W      = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [LANE_W-1:0] in_lane,
   output logic [IDX_W-1:0]  idx_out,
   input  logic [SH_W-1:0]   shift_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [LANE_W-1:0] out_lane,
   output logic [IDX_W-1:0]  out_idx,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   cnt;
   logic               in_xfer, out_xfer, last_lane;
   logic [LANE_W-1:0]  rot;

   assign in_ready  = (state == RUN) && (!out_valid || out_ready);
   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = out_valid && out_ready;
   assign last_lane = (cnt == IDX_W'(NUM_LANES - 1));
   assign idx_out   = cnt;
   assign busy      = (state == RUN) || (state == FLUSH);
   assign done      = (state == DONE);

   // A right shift by LANE_W yields zero, so shift_in=0 passes the lane through.
   assign rot = (in_lane << shift_in) |
                (in_lane >> ((SH_W+1)'(LANE_W) - (SH_W+1)'(shift_in)));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (in_xfer && last_lane) state_nxt = FLUSH;
         FLUSH:   if (!out_valid || out_xfer) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_lane  <= '0;
         out_idx   <= '0;
      end else begin
         state <= state_nxt;

         // Counter parks on the last index through FLUSH/DONE and restarts from IDLE.
         if (state == IDLE || state_nxt == IDLE)
            cnt <= '0;
         else if (in_xfer && !last_lane)
            cnt <= cnt + IDX_W'(1);

         if (in_xfer) begin
            out_lane  <= rot;
            out_idx   <= cnt;
            out_valid <= 1'b1;
         end else if (out_xfer) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_lane_rotate_seq.sv
// Scoreboard bench for lane_rotate_seq with a behavioural offset decoder.
module tb_lane_rotate_seq;

   logic        clk = 1'b0;
   logic        rst, start, in_valid, in_ready, out_valid, out_ready, busy, done;
   logic [63:0] in_lane, out_lane;
   logic [4:0]  idx_out, out_idx;
   logic [5:0]  shift_in;

   always #5 clk = ~clk;

   // Offset decoder model, combinational on idx_out.
   function automatic logic [5:0] rho(input logic [4:0] i);
      case (i)
         5'd0:  return 6'd21; 5'd1:  return 6'd8;  5'd2:  return 6'd18;
         5'd3:  return 6'd2;  5'd4:  return 6'd56; 5'd5:  return 6'd14;
         5'd6:  return 6'd1;  5'd7:  return 6'd28; 5'd8:  return 6'd27;
         5'd9:  return 6'd61; 5'd10: return 6'd36; 5'd11: return 6'd44;
         5'd12: return 6'd0;  5'd13: return 6'd6;  5'd14: return 6'd62;
         5'd15: return 6'd55; 5'd16: return 6'd20; 5'd17: return 6'd3;
         5'd18: return 6'd10; 5'd19: return 6'd43; 5'd20: return 6'd25;
         5'd21: return 6'd39; 5'd22: return 6'd41; 5'd23: return 6'd45;
         5'd24: return 6'd15;
         default: return 6'd0;
      endcase
   endfunction

   assign shift_in = rho(idx_out);

   lane_rotate_seq dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_lane(in_lane), .idx_out(idx_out), .shift_in(shift_in), .out_valid(out_valid),
      .out_ready(out_ready), .out_lane(out_lane), .out_idx(out_idx), .busy(busy), .done(done)
   );

   typedef struct packed { logic [4:0] idx; logic [63:0] lane; } exp_t;

   exp_t        sbq[$];
   int          n_tests = 0, n_fail = 0;
   int          exp_cnt, done_cnt, out_cnt, blk_id;
   logic        hold_v = 1'b0;
   logic [63:0] hold_lane;
   logic [4:0]  hold_idx;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] rotl(input logic [63:0] x, input int s);
      logic [63:0] r;
      for (int i = 0; i < 64; i++) r[(i + s) % 64] = x[i];
      return r;
   endfunction

   function automatic logic [63:0] lane_data(input int blk, input int i);
      logic [63:0] h;
      if (blk == 0) begin
         case (i)
            0:  return 64'h1;
            9:  return 64'h8;
            12: return 64'hDEAD_BEEF_0123_4567;
            14: return 64'h1;
            default: ;
         endcase
      end
      h = 64'h9E37_79B9_7F4A_7C15 * 64'(blk * 32 + i + 1);
      return h ^ (h >> 29);
   endfunction

   // Hand-computed results for the directed lanes of block 0.
   function automatic logic [63:0] exp_lane(input int blk, input int i);
      if (blk == 0) begin
         case (i)
            0:  return 64'h0000_0000_0020_0000;
            9:  return 64'h1;
            12: return 64'hDEAD_BEEF_0123_4567;
            14: return 64'h4000_0000_0000_0000;
            default: ;
         endcase
      end
      return rotl(lane_data(blk, i), int'(rho(5'(i))));
   endfunction

   // One clock: observe at negedge, then return 1 time unit after the posedge.
   task automatic step();
      exp_t e;
      @(negedge clk);
      if (rst) begin
         sbq.delete();
         hold_v = 1'b0;
      end else begin
         if (hold_v) begin
            chk("hold_lane", out_lane, hold_lane);
            chk("hold_idx", 64'(out_idx), 64'(hold_idx));
         end
         if (out_valid && !out_ready) chk("bp_in_ready", 64'(in_ready), 64'd0);
         if (in_valid && in_ready) begin
            chk("idx_out", 64'(idx_out), 64'(exp_cnt));
            e.idx  = 5'(exp_cnt);
            e.lane = exp_lane(blk_id, exp_cnt);
            sbq.push_back(e);
            exp_cnt++;
         end
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) chk("sb_empty", 64'd1, 64'd0);
            else begin
               e = sbq.pop_front();
               chk("out_idx", 64'(out_idx), 64'(e.idx));
               chk("out_lane", out_lane, e.lane);
            end
            out_cnt++;
         end
         if (done) done_cnt++;
         hold_v    = out_valid && !out_ready;
         hold_lane = out_lane;
         hold_idx  = out_idx;
      end
      @(posedge clk);
      #1;
   endtask

   // bp_len<0 selects random out_ready; abort_at>=0 resets after that many lanes.
   task automatic run_block(input int blk, input int bp_at, input int bp_len,
                            input int spur_at, input int abort_at, input int exp_cyc);
      int cyc;
      blk_id = blk; exp_cnt = 0; out_cnt = 0; done_cnt = 0;
      start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      step();
      start = 1'b0;
      cyc = 1;
      while (done_cnt == 0 && cyc < 400) begin
         in_valid = (exp_cnt < 25);
         in_lane  = lane_data(blk, exp_cnt);
         if (bp_len < 0) out_ready = 1'($urandom_range(0, 1));
         else            out_ready = !(cyc >= bp_at && cyc < bp_at + bp_len);
         start = (cyc == spur_at);
         if (abort_at >= 0 && exp_cnt == abort_at) begin
            rst = 1'b1;
            step();
            rst = 1'b0; start = 1'b0; in_valid = 1'b0;
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_idx_out", 64'(idx_out), 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd0);
            return;
         end
         step();
         cyc++;
      end
      start = 1'b0;
      if (done_cnt == 0) chk("done_timeout", 64'd0, 64'd1);
      if (exp_cyc > 0) chk("stream_cycles", 64'(cyc - 1), 64'(exp_cyc));
      chk("out_count", 64'(out_cnt), 64'd25);
      chk("sb_drained", 64'(sbq.size()), 64'd0);
      // Spurious in_valid in IDLE right after done: must be ignored.
      in_valid = 1'b1;
      out_ready = 1'b1;
      step();
      chk("post_in_ready", 64'(in_ready), 64'd0);
      chk("post_busy", 64'(busy), 64'd0);
      chk("post_done", 64'(done), 64'd0);
      chk("done_pulses", 64'(done_cnt), 64'd1);
      in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_lane = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_in_ready", 64'(in_ready), 64'd0);
      chk("reset_idx_out", 64'(idx_out), 64'd0);
      chk("reset_out_lane", out_lane, 64'd0);
      rst = 1'b0;

      // in_valid while IDLE: no transfer, no state change.
      in_valid = 1'b1; in_lane = 64'h1234;
      repeat (3) step();
      chk("idle_idx_out", 64'(idx_out), 64'd0);
      chk("idle_out_valid", 64'(out_valid), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
      in_valid = 1'b0;

      run_block(0, 0, 0, -1, -1, 27);   // full-rate stream with directed lanes
      run_block(1, 8, 5, 12, -1, 0);    // backpressure plus spurious start
      run_block(2, 0, 0, -1, 10, 0);    // reset after 10 lanes
      run_block(3, 3, 2, -1, -1, 0);    // fresh block after the reset
      run_block(4, 0, -1, -1, -1, 0);   // random out_ready

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
